// File: rtl/dma_cmd_arbiter_pkg.sv
// Shared definitions for the DMA command arbiter slice.
//   CMD_TYPE_WR / CMD_TYPE_RD : encoding of out_cmd_type
//   owner_e                   : which requester currently holds the turn
//   MAX_OUTST                 : ceiling on outstanding commands per type
//   BURST_MAX                 : saturation value of the burst counter
//   eff_weight()              : maps a configured weight of 0 to 1
package dma_cmd_arbiter_pkg;

  localparam logic CMD_TYPE_WR = 1'b0;
  localparam logic CMD_TYPE_RD = 1'b1;

  localparam int unsigned MAX_OUTST = 64;
  localparam int unsigned BURST_MAX = 15;

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_e;

  function automatic logic [3:0] eff_weight(input logic [3:0] w);
    return (w == 4'd0) ? 4'd1 : w;
  endfunction

endpackage

// File: rtl/dma_credit_counter.sv
// Outstanding-command credit counter for one command type.
//   clk, rst : clock and synchronous active-high reset
//   inc      : one command of this type accepted this cycle
//   dec      : one command of this type completed this cycle
//   limit    : configured credit limit (values above MAX_OUTST are clamped)
//   count    : current number of outstanding commands
//   eligible : count is below the limit, a new command may be granted
//   err      : sticky, a completion arrived while count was already zero
module dma_credit_counter
  import dma_cmd_arbiter_pkg::*;
#(
  parameter int unsigned CNTW = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  input  logic [CNTW-1:0] limit,
  output logic [CNTW-1:0] count,
  output logic            eligible,
  output logic            err
);

  logic [CNTW-1:0] lim_eff;
  logic [CNTW-1:0] count_nxt;
  logic            underflow;

  always_comb begin
    lim_eff = (limit > CNTW'(MAX_OUTST)) ? CNTW'(MAX_OUTST) : limit;
    // A limit lowered below the current count simply stops eligibility
    // until completions drain the count; it is not an error.
    eligible = (count < lim_eff);
  end

  // A completion with nothing outstanding is ignored for counting and only
  // raises the sticky error; a legitimate completion and a new acceptance
  // in the same cycle cancel out.
  always_comb begin
    underflow = dec && (count == '0);
    count_nxt = count;
    if (dec && !underflow) count_nxt = count_nxt - CNTW'(1);
    if (inc)               count_nxt = count_nxt + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      if (underflow) err <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_cmd_arbiter.sv
// Shares one DMA command-encoder port between the write and read channels.
// Weighted round-robin between the two requesters, per-type outstanding
// credits, and one registered output stage toward the encoder.
//   clk_afu, rst          : clock, synchronous active-high reset
//   wr_cmd_*              : write channel command (valid/ready handshake)
//   rd_cmd_*              : read channel command (valid/ready handshake)
//   out_cmd_*             : shared command port (valid/ready handshake)
//   wr/rd_done_valid      : credit return, one completed command per pulse
//   cfg_wr/rd_weight      : consecutive grants per turn (0 behaves as 1)
//   cfg_wr/rd_max_outst   : credit limits 0..64 (0 blocks that type)
//   wr/rd_outstanding     : current outstanding counts
//   arb_idle              : nothing held on the output and both counts zero
//   credit_err            : sticky credit-return underflow flag
module dma_cmd_arbiter
  import dma_cmd_arbiter_pkg::*;
#(
  parameter int unsigned TAGW = 6,
  parameter int unsigned CNTW = 7
) (
  input  logic            clk_afu,
  input  logic            rst,

  input  logic            wr_cmd_valid,
  output logic            wr_cmd_ready,
  input  logic [1023:0]   wr_cmd_data,
  input  logic [127:0]    wr_cmd_be,
  input  logic [63:0]     wr_cmd_ea,
  input  logic [TAGW-1:0] wr_cmd_tag,

  input  logic            rd_cmd_valid,
  output logic            rd_cmd_ready,
  input  logic [127:0]    rd_cmd_be,
  input  logic [63:0]     rd_cmd_ea,
  input  logic [TAGW-1:0] rd_cmd_tag,

  output logic            out_cmd_valid,
  input  logic            out_cmd_ready,
  output logic            out_cmd_type,
  output logic [1023:0]   out_cmd_data,
  output logic [127:0]    out_cmd_be,
  output logic [63:0]     out_cmd_ea,
  output logic [TAGW-1:0] out_cmd_tag,

  input  logic            wr_done_valid,
  input  logic            rd_done_valid,

  input  logic [3:0]      cfg_wr_weight,
  input  logic [3:0]      cfg_rd_weight,
  input  logic [CNTW-1:0] cfg_wr_max_outst,
  input  logic [CNTW-1:0] cfg_rd_max_outst,

  output logic [CNTW-1:0] wr_outstanding,
  output logic [CNTW-1:0] rd_outstanding,
  output logic            arb_idle,
  output logic            credit_err
);

  owner_e     owner_q, owner_d;
  logic [3:0] burst_q, burst_d;

  logic       wr_credit_ok, rd_credit_ok;
  logic       wr_err, rd_err;
  logic       wr_elig, rd_elig;
  logic       own_elig, oth_elig;
  logic [3:0] own_weight;
  logic       load;
  logic       grant_own, grant_oth;
  logic       grant_wr, grant_rd;

  // ---------------------------------------------------------------------
  // Credit counters
  // ---------------------------------------------------------------------
  dma_credit_counter #(.CNTW(CNTW)) u_wr_credit (
    .clk      (clk_afu),
    .rst      (rst),
    .inc      (grant_wr),
    .dec      (wr_done_valid),
    .limit    (cfg_wr_max_outst),
    .count    (wr_outstanding),
    .eligible (wr_credit_ok),
    .err      (wr_err)
  );

  dma_credit_counter #(.CNTW(CNTW)) u_rd_credit (
    .clk      (clk_afu),
    .rst      (rst),
    .inc      (grant_rd),
    .dec      (rd_done_valid),
    .limit    (cfg_rd_max_outst),
    .count    (rd_outstanding),
    .eligible (rd_credit_ok),
    .err      (rd_err)
  );

  // ---------------------------------------------------------------------
  // Weighted round-robin: owner/burst next-state and grant
  // ---------------------------------------------------------------------
  always_comb begin
    wr_elig    = wr_cmd_valid && wr_credit_ok;
    rd_elig    = rd_cmd_valid && rd_credit_ok;
    load       = !out_cmd_valid || out_cmd_ready;

    own_elig   = (owner_q == OWN_WR) ? wr_elig : rd_elig;
    oth_elig   = (owner_q == OWN_WR) ? rd_elig : wr_elig;
    own_weight = (owner_q == OWN_WR) ? eff_weight(cfg_wr_weight)
                                     : eff_weight(cfg_rd_weight);

    grant_own  = 1'b0;
    grant_oth  = 1'b0;
    owner_d    = owner_q;
    burst_d    = burst_q;

    if (load) begin
      if (own_elig && (burst_q < own_weight)) begin
        grant_own = 1'b1;
        burst_d   = (burst_q == 4'(BURST_MAX)) ? burst_q : burst_q + 4'd1;
      end else if (oth_elig) begin
        grant_oth = 1'b1;
        owner_d   = (owner_q == OWN_WR) ? OWN_RD : OWN_WR;
        burst_d   = 4'd1;
      end else if (own_elig) begin
        // Turn exhausted but nobody else wants the port: start a new turn.
        grant_own = 1'b1;
        burst_d   = 4'd1;
      end
    end

    grant_wr = (grant_own && (owner_q == OWN_WR)) ||
               (grant_oth && (owner_q == OWN_RD));
    grant_rd = (grant_own && (owner_q == OWN_RD)) ||
               (grant_oth && (owner_q == OWN_WR));

    wr_cmd_ready = grant_wr;
    rd_cmd_ready = grant_rd;
  end

  always_ff @(posedge clk_afu) begin
    if (rst) begin
      owner_q <= OWN_WR;
      burst_q <= 4'd0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // ---------------------------------------------------------------------
  // Registered output stage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_afu) begin
    if (rst) begin
      out_cmd_valid <= 1'b0;
      out_cmd_type  <= CMD_TYPE_WR;
      out_cmd_data  <= '0;
      out_cmd_be    <= '0;
      out_cmd_ea    <= '0;
      out_cmd_tag   <= '0;
    end else if (load) begin
      out_cmd_valid <= grant_wr || grant_rd;
      if (grant_wr) begin
        out_cmd_type <= CMD_TYPE_WR;
        out_cmd_data <= wr_cmd_data;
        out_cmd_be   <= wr_cmd_be;
        out_cmd_ea   <= wr_cmd_ea;
        out_cmd_tag  <= wr_cmd_tag;
      end else if (grant_rd) begin
        out_cmd_type <= CMD_TYPE_RD;
        out_cmd_data <= '0;
        out_cmd_be   <= rd_cmd_be;
        out_cmd_ea   <= rd_cmd_ea;
        out_cmd_tag  <= rd_cmd_tag;
      end
    end
  end

  always_comb begin
    arb_idle   = !out_cmd_valid && (wr_outstanding == '0) && (rd_outstanding == '0);
    credit_err = wr_err || rd_err;
  end

endmodule

// File: doc/dma_cmd_arbiter.md
Name: dma_cmd_arbiter

Overview:
- Shares one DMA command-encoder port between the write and read channels of the data bridge.
- Weighted round-robin selects between the two requesters.
- Per-type outstanding-command credits are enforced; one registered output stage drives the shared port.
- Sits between the data bridge channel command outputs (dma_wr_cmd_*, dma_rd_cmd_*) and the single command encoder.

Parameters:
- TAGW, 6, width of the DMA command tag.
- CNTW, 7, width of the outstanding counters (range 0..64).

Ports:
- clk_afu  in  1  AFU clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_cmd_valid  in  1  write channel command valid
- wr_cmd_ready  out  1  write command accepted this cycle
- wr_cmd_data  in  1024  write payload
- wr_cmd_be  in  128  write byte enables
- wr_cmd_ea  in  64  write effective address
- wr_cmd_tag  in  TAGW  write tag
- rd_cmd_valid  in  1  read channel command valid
- rd_cmd_ready  out  1  read command accepted this cycle
- rd_cmd_be  in  128  read byte enables
- rd_cmd_ea  in  64  read effective address
- rd_cmd_tag  in  TAGW  read tag
- out_cmd_valid  out  1  shared command valid
- out_cmd_ready  in  1  encoder accepts
- out_cmd_type  out  1  0 = write, 1 = read
- out_cmd_data  out  1024  payload; zero for reads
- out_cmd_be  out  128  byte enables
- out_cmd_ea  out  64  effective address
- out_cmd_tag  out  TAGW  tag
- wr_done_valid  in  1  one write command fully completed (credit return)
- rd_done_valid  in  1  one read command fully completed (credit return)
- cfg_wr_weight  in  4  consecutive write grants per turn; 0 treated as 1
- cfg_rd_weight  in  4  consecutive read grants per turn; 0 treated as 1
- cfg_wr_max_outst  in  CNTW  write credit limit, 0..64; 0 blocks writes
- cfg_rd_max_outst  in  CNTW  read credit limit, 0..64; 0 blocks reads
- wr_outstanding  out  CNTW  current write count
- rd_outstanding  out  CNTW  current read count
- arb_idle  out  1  no out_cmd_valid and both counts zero
- credit_err  out  1  sticky: done received while the matching count was 0

Behaviour:
- Reset values:
  - out_cmd_valid = 0; all out_cmd_* fields = 0.
  - Both counts = 0; credit_err = 0; arb_idle = 1.
  - Owner = WR; burst counter = 0.
- Eligibility:
  - wr_elig = wr_cmd_valid && wr_outstanding < cfg_wr_max_outst.
  - rd_elig is defined the same way.
- Load condition: load = !out_cmd_valid || out_cmd_ready. This gives full throughput of one command per cycle.
- Grant, evaluated combinationally when load is true:
  - Owner eligible and burst < weight: grant owner.
  - Otherwise, if the other requester is eligible: grant other; owner switches to other; burst = 1.
  - Otherwise, if the owner is eligible: grant owner and reset burst to 1. This covers weight exhausted with no competitor.
  - Otherwise: no grant; owner and burst are held.
- On a grant to the owner, burst increments, saturating at 15.
- wr_cmd_ready / rd_cmd_ready: asserted only for the granted requester on a load cycle; never both in the same cycle.
- Latency: an accepted command appears on out_cmd_* the next cycle.
- Output fields hold stable while out_cmd_valid && !out_cmd_ready.
- On load with no grant, out_cmd_valid goes to 0.
- Outstanding counters:
  - Increment on acceptance (ready && valid).
  - Decrement on the matching *_done_valid.
  - Increment and decrement in the same cycle: net unchanged.
  - Done at count 0: counter stays 0 and credit_err sets. credit_err clears only on rst.
- A credit limit lowered below the current count blocks new grants until the count drains; no error is flagged.
- Reset mid-transfer discards the held command. Upstream re-issues.

Decomposition:
- Shared package holds:
  - CMD_TYPE_WR = 1'b0, CMD_TYPE_RD = 1'b1.
  - Owner enum {OWN_WR, OWN_RD}.
  - MAX_OUTST = 64.
- One natural sub-module, dma_credit_counter, instantiated twice. Interface: inc, dec, limit, count, eligible, err.

Test Plan:
- Reset, then only writes valid (weights 2/2, limits 64): 5 writes issue back-to-back in 5 cycles, type 0, tags preserved; wr_outstanding = 5.
- Both valid continuously, weights wr 3 / rd 1, out_cmd_ready = 1: issue order W W W R W W W R; no cycle with both readys high.
- cfg_rd_max_outst = 2, rd valid, no rd_done: exactly 2 reads issue and rd_cmd_ready stays 0. One rd_done pulse: a 3rd read issues the next cycle.
- out_cmd_ready held 0 for 4 cycles with a command held: out_cmd_* unchanged, both readys 0. Release: next command follows with no bubble.
- Write accept and wr_done in the same cycle at count 3: count stays 3. wr_done at count 0: count stays 0 and credit_err = 1 until rst.
- rst asserted while out_cmd_valid = 1 and counts = 4/2: the next cycle shows out_cmd_valid = 0, counts 0, arb_idle = 1, credit_err = 0.
